parking_slot_scheduler: RTL and testbench

- Sequential allocator for the lot's slot-occupancy bitmap.
- Arbitrates entry requests from several entry gates round-robin and assigns each winner the lowest-numbered free slot.
- Applies exit releases and owns the registered occupancy vector and free-slot count consumed by displays and the capacity logic.
- Sits between the gate controllers and the capacity datapath: the only writer of occupancy.

---
 rtl/parking_slot_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_parking_slot_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_scheduler.sv
// rtl/parking_slot_scheduler.sv - round-robin entry arbiter and slot-occupancy allocator (optional PARK_STATS_EN counters)
module parking_slot_scheduler #(
    parameter int N_GATES = 2,
    parameter int N_SLOTS = 8,
    localparam int SW = $clog2(N_SLOTS),
    localparam int CW = $clog2(N_SLOTS + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_GATES-1:0] i_entry_req,
    output logic [N_GATES-1:0] o_entry_ack,
    output logic               o_entry_ok,
    output logic [SW-1:0]      o_entry_slot,
    input  logic               i_exit_valid,
    input  logic [SW-1:0]      i_exit_slot,
    output logic               o_exit_err,
    output logic [N_SLOTS-1:0] o_occupancy,
    output logic [CW-1:0]      o_free_count,
    output logic               o_busy
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]        o_entries_total,
    output logic [7:0]         o_denied_total
`endif
);

    localparam int GW = (N_GATES > 1) ? $clog2(N_GATES) : 1;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_SEARCH       = 2'd1,
        S_GRANT        = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    state_t             r_state;
    logic [GW-1:0]      r_rr_ptr;
    logic [GW-1:0]      r_winner;
    logic [SW-1:0]      r_slot;
    logic               r_found;
    logic [N_GATES-1:0] r_ack;
    logic               r_ok;
    logic [SW-1:0]      r_slot_out;
    logic               r_err;
    logic [N_SLOTS-1:0] r_occ;
    logic [CW-1:0]      r_free;

    logic               w_hit;
    logic [GW-1:0]      w_winner;
    logic [GW-1:0]      w_idx;
    logic               w_free_found;
    logic [SW-1:0]      w_free_idx;
    logic               w_exit_in_range;
    logic               w_exit_ok;
    logic               w_grant;
    logic [N_SLOTS-1:0] w_exit_mask;
    logic [N_SLOTS-1:0] w_grant_mask;

    // Round-robin pick: first requesting gate scanning upward from rr_ptr+1 with wrap
    always_comb begin
        w_hit    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= N_GATES; i++) begin
            w_idx = GW'((int'(r_rr_ptr) + i) % N_GATES);
            if (!w_hit && i_entry_req[w_idx]) begin
                w_hit    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Lowest free slot of the registered occupancy (descending scan so the lowest index wins)
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = SW'(i);
            end
        end
    end

    // Release is honoured only for an in-range, currently occupied slot
    always_comb begin
        w_exit_in_range = int'(i_exit_slot) < N_SLOTS;
        w_exit_ok       = i_exit_valid && w_exit_in_range && r_occ[i_exit_slot];
        w_exit_mask     = w_exit_ok ? (N_SLOTS'(1) << i_exit_slot) : '0;
        w_grant         = (r_state == S_GRANT) && r_found;
        w_grant_mask    = w_grant ? (N_SLOTS'(1) << r_slot) : '0;
    end

    // Occupancy, free count and exit error: updated every cycle regardless of FSM state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_occ  <= '0;
            r_free <= CW'(N_SLOTS);
            r_err  <= 1'b0;
        end else begin
            r_occ <= (r_occ & ~w_exit_mask) | w_grant_mask;
            r_err <= i_exit_valid && !w_exit_ok;
            case ({w_exit_ok, w_grant})
                2'b10:   r_free <= r_free + CW'(1);
                2'b01:   r_free <= r_free - CW'(1);
                default: r_free <= r_free;
            endcase
        end
    end

    // Entry FSM: IDLE -> SEARCH -> GRANT -> RELEASE_WAIT, with registered ack/ok/slot
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= GW'(N_GATES - 1);
            r_winner   <= '0;
            r_slot     <= '0;
            r_found    <= 1'b0;
            r_ack      <= '0;
            r_ok       <= 1'b0;
            r_slot_out <= '0;
        end else begin
            r_ack      <= '0;
            r_ok       <= 1'b0;
            r_slot_out <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_winner <= w_winner;
                        r_state  <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    r_slot  <= w_free_idx;
                    r_found <= w_free_found;
                    r_state <= S_GRANT;
                end
                S_GRANT: begin
                    r_ack      <= N_GATES'(1) << r_winner;
                    r_ok       <= r_found;
                    r_slot_out <= r_found ? r_slot : '0;
                    r_rr_ptr   <= r_winner;
                    r_state    <= S_RELEASE_WAIT;
                end
                S_RELEASE_WAIT: begin
                    if (!i_entry_req[r_winner]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PARK_STATS_EN
    logic [15:0] r_entries_total;
    logic [7:0]  r_denied_total;

    // Saturating grant/denial counters, stepped once per GRANT cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_entries_total <= '0;
            r_denied_total  <= '0;
        end else if (r_state == S_GRANT) begin
            if (r_found && (r_entries_total != '1)) begin
                r_entries_total <= r_entries_total + 16'd1;
            end else if (!r_found && (r_denied_total != '1)) begin
                r_denied_total <= r_denied_total + 8'd1;
            end
        end
    end

    assign o_entries_total = r_entries_total;
    assign o_denied_total  = r_denied_total;
`endif

    assign o_entry_ack  = r_ack;
    assign o_entry_ok   = r_ok;
    assign o_entry_slot = r_slot_out;
    assign o_exit_err   = r_err;
    assign o_occupancy  = r_occ;
    assign o_free_count = r_free;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_parking_slot_scheduler.sv
// tb/tb_parking_slot_scheduler.sv - scoreboard bench for parking_slot_scheduler
module tb_parking_slot_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] i_entry_req = '0;
    logic [1:0] o_entry_ack;
    logic       o_entry_ok;
    logic [2:0] o_entry_slot;
    logic       i_exit_valid = 1'b0;
    logic [2:0] i_exit_slot = '0;
    logic       o_exit_err;
    logic [7:0] o_occupancy;
    logic [3:0] o_free_count;
    logic       o_busy;
`ifdef PARK_STATS_EN
    logic [15:0] o_entries_total;
    logic [7:0]  o_denied_total;
`endif

    parking_slot_scheduler #(.N_GATES(2), .N_SLOTS(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_entry_req  (i_entry_req),
        .o_entry_ack  (o_entry_ack),
        .o_entry_ok   (o_entry_ok),
        .o_entry_slot (o_entry_slot),
        .i_exit_valid (i_exit_valid),
        .i_exit_slot  (i_exit_slot),
        .o_exit_err   (o_exit_err),
        .o_occupancy  (o_occupancy),
        .o_free_count (o_free_count),
        .o_busy       (o_busy)
`ifdef PARK_STATS_EN
        ,
        .o_entries_total (o_entries_total),
        .o_denied_total  (o_denied_total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ack;
        logic       ok;
        logic [2:0] slot;
        logic [7:0] occ;
        logic [3:0] free;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_occ = '0;
    int         m_entries = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_free(input logic [7:0] occ);
        return 4'(8 - $countones(occ));
    endfunction

    // Reference allocation: lowest free slot of the bench's occupancy model
    task automatic predict(input int g);
        exp_t e;
        e.ack  = 2'(1 << g);
        e.ok   = 1'b0;
        e.slot = '0;
        for (int i = 0; i < 8; i++) begin
            if (!e.ok && !m_occ[i]) begin
                e.ok     = 1'b1;
                e.slot   = 3'(i);
                m_occ[i] = 1'b1;
            end
        end
        if (e.ok) m_entries++;
        e.occ  = m_occ;
        e.free = model_free(m_occ);
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every ack pulse pops and checks one expected grant
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (o_entry_ack != 2'b00)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, o_entry_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack",   {30'd0, o_entry_ack}, {30'd0, e.ack});
                chk("ok",    {31'd0, o_entry_ok}, {31'd0, e.ok});
                chk("slot",  {29'd0, o_entry_slot}, {29'd0, e.slot});
                chk("occ",   {24'd0, o_occupancy}, {24'd0, e.occ});
                chk("free",  {28'd0, o_free_count}, {28'd0, e.free});
            end
        end
    end

    // Called at a negedge with the FSM idle; single gate request held until ack
    task automatic do_req(input int g);
        int cyc;
        predict(g);
        i_entry_req[g] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!o_entry_ack[g] && cyc < 20);
        chk("ack_latency", cyc, 3);
        i_entry_req[g] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_exit(input int s);
        logic exp_err;
        exp_err = !m_occ[s];
        i_exit_valid = 1'b1;
        i_exit_slot  = 3'(s);
        @(negedge clk);
        i_exit_valid = 1'b0;
        if (!exp_err) m_occ[s] = 1'b0;
        chk("exit_err",  {31'd0, o_exit_err}, {31'd0, exp_err});
        chk("exit_occ",  {24'd0, o_occupancy}, {24'd0, m_occ});
        chk("exit_free", {28'd0, o_free_count}, {28'd0, model_free(m_occ)});
        @(negedge clk);
        chk("exit_err_pulse", {31'd0, o_exit_err}, 32'd0);
    endtask

    initial begin
        int cyc;
        int g;
        exp_t e;

        repeat (3) @(negedge clk);
        chk("rst_ack",  {30'd0, o_entry_ack}, 32'd0);
        chk("rst_ok",   {31'd0, o_entry_ok}, 32'd0);
        chk("rst_slot", {29'd0, o_entry_slot}, 32'd0);
        chk("rst_err",  {31'd0, o_exit_err}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_occ",  {24'd0, o_occupancy}, 32'd0);
        chk("rst_free", {28'd0, o_free_count}, 32'd8);
        rst = 1'b0;
        @(negedge clk);

        // First grant, then fill slots 1..6 and punch holes to reach 0x55
        do_req(0);
        for (int i = 0; i < 6; i++) do_req((i % 2 == 0) ? 1 : 0);
        do_exit(1);
        do_exit(3);
        do_exit(5);
        chk("preload_occ", {24'd0, o_occupancy}, 32'h55);
        do_req(1);

        // Release of a free slot
        do_exit(5);

        // Fill to full, then a denied request
        for (int i = 0; i < 3; i++) do_req(i % 2);
        chk("full_occ", {24'd0, o_occupancy}, 32'hFF);
        do_req(0);
`ifdef PARK_STATS_EN
        chk("denied_total",  {24'd0, o_denied_total}, 32'd1);
        chk("entries_total", {16'd0, o_entries_total}, m_entries);
`endif

        // Release slot 3 on the very edge that grants slot 2
        do_exit(2);
        e.ack  = 2'b10;
        e.ok   = 1'b1;
        e.slot = 3'd2;
        m_occ  = 8'hF7;
        e.occ  = m_occ;
        e.free = model_free(m_occ);
        m_entries++;
        sb.push_back(e);
        i_entry_req[1] = 1'b1;
        repeat (2) @(negedge clk);
        i_exit_valid = 1'b1;
        i_exit_slot  = 3'd3;
        @(negedge clk);
        i_exit_valid = 1'b0;
        chk("net_ack",     {30'd0, o_entry_ack}, 32'd2);
        chk("net_exit_err", {31'd0, o_exit_err}, 32'd0);
        i_entry_req[1] = 1'b0;
        @(negedge clk);

        // Simultaneous requests from reset: service alternates 0,1,0,1
        rst = 1'b1;
        m_occ = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) predict(k % 2);
        i_entry_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (o_entry_ack == 2'b00 && cyc < 20);
            chk("alt_order", {30'd0, o_entry_ack}, 32'(1 << g));
            if (k == 3) begin
                i_entry_req = 2'b00;
                @(negedge clk);
            end else begin
                i_entry_req[g] = 1'b0;
                @(negedge clk);
                i_entry_req[g] = 1'b1;
            end
        end
        chk("alt_occ", {24'd0, o_occupancy}, 32'h0F);

        // Reset in SEARCH: async clear, pending ack lost, held request served afresh
        i_entry_req[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("search_busy", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        chk("arst_occ",  {24'd0, o_occupancy}, 32'd0);
        chk("arst_free", {28'd0, o_free_count}, 32'd8);
        m_occ = '0;
        @(negedge clk);
        predict(0);
        rst = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!o_entry_ack[0] && cyc < 20);
        chk("post_rst_latency", cyc, 3);
        i_entry_req[0] = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
